// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises one queued data access and one queued instruction fetch
// onto a single req/ack word memory port, returning read words to MDR and bytes to MBR.
module mem_arbiter #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd,
   input  logic              wr,
   input  logic              fetch,
   input  logic [31:0]       MAR,
   input  logic [31:0]       MDR,
   input  logic [31:0]       PC,
   output logic              stall,
   output logic [31:0]       mdr_in,
   output logic              mdr_load,
   output logic [7:0]        mbr_in,
   output logic              mbr_load,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);
   typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;
   state_t            state_q;
   logic              d_busy_q, d_we_q, f_busy_q, last_f_q;
   logic [ADDR_W-1:0] d_addr_q, f_addr_q;
   logic [31:0]       d_wdata_q;
   logic [1:0]        f_lane_q;
   logic              mem_req_q, mem_we_q, mdr_load_q, mbr_load_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q, mdr_in_q;
   logic [7:0]        mbr_in_q;
   logic              d_acc, f_acc, d_done, f_done, d_wait, f_wait, can_launch, go_d, go_f;
   logic              d_we_sel;
   logic [ADDR_W-1:0] d_addr_sel, f_addr_sel;
   logic [31:0]       d_wdata_sel;
   logic              unused;

   assign unused = ^{MAR[31:ADDR_W], PC[31:ADDR_W+2]};

   assign stall  = ((rd | wr) & d_busy_q) | (fetch & f_busy_q);
   assign d_acc  = (rd | wr) & ~stall;
   assign f_acc  = fetch & ~stall;
   assign d_done = (state_q == DATA) & mem_ack;
   assign f_done = (state_q == FETCH) & mem_ack;
   // a slot "waits" when it holds a request that is not the one currently on the port
   assign d_wait = (d_busy_q & (state_q != DATA)) | d_acc;
   assign f_wait = (f_busy_q & (state_q != FETCH)) | f_acc;
   assign can_launch = (state_q == IDLE) | d_done | f_done;
   assign go_d = can_launch & d_wait & (~f_wait | last_f_q | (d_acc & f_acc));
   assign go_f = can_launch & f_wait & ~go_d;

   assign d_we_sel    = d_acc ? wr : d_we_q;
   assign d_addr_sel  = d_acc ? MAR[ADDR_W-1:0] : d_addr_q;
   assign d_wdata_sel = d_acc ? MDR : d_wdata_q;
   assign f_addr_sel  = f_acc ? PC[ADDR_W+1:2] : f_addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_f_q    <= 1'b1;
         d_busy_q    <= 1'b0;
         d_we_q      <= 1'b0;
         d_addr_q    <= '0;
         d_wdata_q   <= '0;
         f_busy_q    <= 1'b0;
         f_addr_q    <= '0;
         f_lane_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mdr_in_q    <= '0;
         mdr_load_q  <= 1'b0;
         mbr_in_q    <= '0;
         mbr_load_q  <= 1'b0;
      end else begin
         mdr_load_q <= d_done & ~d_we_q;
         mbr_load_q <= f_done;
         if (d_done & ~d_we_q) mdr_in_q <= mem_rdata;
         if (f_done) mbr_in_q <= mem_rdata[{f_lane_q, 3'b000} +: 8];
         if (d_acc) begin
            d_we_q    <= wr;
            d_addr_q  <= MAR[ADDR_W-1:0];
            d_wdata_q <= MDR;
         end
         if (f_acc) begin
            f_addr_q <= PC[ADDR_W+1:2];
            f_lane_q <= PC[1:0];
         end
         d_busy_q <= d_acc | (d_busy_q & ~d_done);
         f_busy_q <= f_acc | (f_busy_q & ~f_done);
         if (go_d) begin
            state_q     <= DATA;
            last_f_q    <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_sel;
            mem_addr_q  <= d_addr_sel;
            mem_wdata_q <= d_wdata_sel;
         end else if (go_f) begin
            state_q    <= FETCH;
            last_f_q   <= 1'b1;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= f_addr_sel;
         end else if (d_done | f_done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
         end
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mdr_in    = mdr_in_q;
   assign mdr_load  = mdr_load_q;
   assign mbr_in    = mbr_in_q;
   assign mbr_load  = mbr_load_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter; inputs change and outputs are
// checked on the falling edge, away from the rising edge the DUT samples on.
module tb_mem_arbiter;
   logic        clk, rst, rd, wr, fetch, stall, mdr_load, mbr_load, mem_req, mem_we, mem_ack;
   logic [31:0] MAR, MDR, PC, mdr_in, mem_wdata, mem_rdata;
   logic [7:0]  mbr_in;
   logic [15:0] mem_addr;
   int          n_vec = 0;
   int          n_err = 0;

   mem_arbiter #(.ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .rd(rd), .wr(wr), .fetch(fetch),
      .MAR(MAR), .MDR(MDR), .PC(PC), .stall(stall),
      .mdr_in(mdr_in), .mdr_load(mdr_load), .mbr_in(mbr_in), .mbr_load(mbr_load),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " req"}, {31'd0, mem_req}, 0);
      check({tag, " we"}, {31'd0, mem_we}, 0);
      check({tag, " mdr_load"}, {31'd0, mdr_load}, 0);
      check({tag, " mbr_load"}, {31'd0, mbr_load}, 0);
      check({tag, " addr"}, {16'd0, mem_addr}, 0);
      check({tag, " wdata"}, mem_wdata, 0);
      check({tag, " mdr_in"}, mdr_in, 0);
      check({tag, " mbr_in"}, {24'd0, mbr_in}, 0);
   endtask

   initial begin
      rst = 1'b0; rd = 0; wr = 0; fetch = 0; MAR = 0; MDR = 0; PC = 0;
      mem_ack = 0; mem_rdata = 0;
      tick(); tick();
      check_zero("reset");
      rst = 1'b1;

      // read from idle, zero-wait memory
      tick(); rd = 1; MAR = 32'h0005;
      #1 check("rd0 stall", {31'd0, stall}, 0);
      tick(); rd = 0;
      check("rd0 req", {31'd0, mem_req}, 1);
      check("rd0 addr", {16'd0, mem_addr}, 32'h5);
      check("rd0 we", {31'd0, mem_we}, 0);
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      tick(); mem_ack = 0;
      check("rd0 load", {31'd0, mdr_load}, 1);
      check("rd0 data", mdr_in, 32'hDEADBEEF);
      check("rd0 req low", {31'd0, mem_req}, 0);
      tick();
      check("rd0 load once", {31'd0, mdr_load}, 0);

      // fetch, lane 2 of word 3
      fetch = 1; PC = 32'h0000000E;
      tick(); fetch = 0;
      check("f0 req", {31'd0, mem_req}, 1);
      check("f0 addr", {16'd0, mem_addr}, 3);
      mem_ack = 1; mem_rdata = 32'h44332211;
      tick(); mem_ack = 0;
      check("f0 load", {31'd0, mbr_load}, 1);
      check("f0 byte", {24'd0, mbr_in}, 32'h33);
      tick();
      check("f0 load once", {31'd0, mbr_load}, 0);

      // fetch, lane 3
      fetch = 1; PC = 32'h0000000F;
      tick(); fetch = 0; mem_ack = 1; mem_rdata = 32'h44332211;
      tick(); mem_ack = 0;
      check("f1 byte", {24'd0, mbr_in}, 32'h44);

      // simultaneous write and fetch: write first, then fetch with no gap
      tick(); wr = 1; MAR = 32'h1; MDR = 32'hA5A5A5A5; fetch = 1; PC = 32'h8;
      tick(); wr = 0; fetch = 0;
      check("wf req", {31'd0, mem_req}, 1);
      check("wf we", {31'd0, mem_we}, 1);
      check("wf addr", {16'd0, mem_addr}, 1);
      check("wf wdata", mem_wdata, 32'hA5A5A5A5);
      mem_ack = 1; mem_rdata = 32'h11223344;
      tick();
      check("wf f req", {31'd0, mem_req}, 1);
      check("wf f we", {31'd0, mem_we}, 0);
      check("wf f addr", {16'd0, mem_addr}, 2);
      check("wf no mdr", {31'd0, mdr_load}, 0);
      tick(); mem_ack = 0;
      check("wf mbr load", {31'd0, mbr_load}, 1);
      check("wf mbr", {24'd0, mbr_in}, 32'h44);
      check("wf req low", {31'd0, mem_req}, 0);

      // stall while a read is outstanding
      tick(); rd = 1; MAR = 32'h10;
      tick(); MAR = 32'h20;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("st stall%0d", i), {31'd0, stall}, 1);
         check($sformatf("st addr%0d", i), {16'd0, mem_addr}, 32'h10);
         if (i < 3) tick();
      end
      mem_ack = 1; mem_rdata = 32'h1111;
      tick(); mem_ack = 0;
      check("st load1", {31'd0, mdr_load}, 1);
      check("st data1", mdr_in, 32'h1111);
      check("st released", {31'd0, stall}, 0);
      check("st req low", {31'd0, mem_req}, 0);
      tick(); rd = 0;
      check("st req2", {31'd0, mem_req}, 1);
      check("st addr2", {16'd0, mem_addr}, 32'h20);
      mem_ack = 1; mem_rdata = 32'h2222;
      tick(); mem_ack = 0;
      check("st data2", mdr_in, 32'h2222);
      check("st load2", {31'd0, mdr_load}, 1);

      // fairness: refill both slots, port alternates data/fetch
      tick(); rd = 1; MAR = 32'h30;
      tick(); rd = 0; fetch = 1; PC = 32'h40;
      check("rr d0", {16'd0, mem_addr}, 32'h30);
      mem_ack = 1; mem_rdata = 32'hCAFE0000;
      tick(); fetch = 0; wr = 1; MAR = 32'h31; MDR = 32'h12345678;
      check("rr f0 addr", {16'd0, mem_addr}, 32'h10);
      check("rr f0 we", {31'd0, mem_we}, 0);
      check("rr f0 req", {31'd0, mem_req}, 1);
      tick(); wr = 0; fetch = 1; PC = 32'h44;
      check("rr d1 addr", {16'd0, mem_addr}, 32'h31);
      check("rr d1 we", {31'd0, mem_we}, 1);
      check("rr d1 wdata", mem_wdata, 32'h12345678);
      tick(); fetch = 0;
      check("rr f1 addr", {16'd0, mem_addr}, 32'h11);
      check("rr f1 we", {31'd0, mem_we}, 0);
      tick(); mem_ack = 0;
      check("rr idle", {31'd0, mem_req}, 0);

      // reset mid-transaction, then a stray ack
      tick(); rd = 1; MAR = 32'h7;
      tick(); rd = 0;
      check("rs req", {31'd0, mem_req}, 1);
      rst = 1'b0;
      #1 check_zero("rs async");
      tick(); rst = 1'b1; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
      tick(); mem_ack = 0;
      check_zero("rs stray ack");
      rd = 1; MAR = 32'h9;
      tick(); rd = 0;
      check("rs new req", {31'd0, mem_req}, 1);
      check("rs new addr", {16'd0, mem_addr}, 32'h9);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
